// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared states, pattern seeds and helpers for the UART echo tester
package uart_echo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ECHO,
    ST_NEXT,
    ST_FINISH
  } state_e;

  localparam logic [7:0] COUNT_SEED = 8'h00;
  localparam logic [7:0] LFSR_SEED  = 8'h01;
  // Feedback taps p[7]^p[5]^p[4]^p[3]
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    return {p[6:0], ^(p & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/echo_pattern_gen.sv
// rtl/echo_pattern_gen.sv - byte pattern source: incrementing counter, or LFSR when ECHO_PRBS_EN is defined
module echo_pattern_gen (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       load_i,
  input  logic       advance_i,
  output logic [7:0] pattern_o
);
  import uart_echo_pkg::*;

  logic [7:0] pattern_q;
  logic [7:0] pattern_d;
  logic [7:0] seed;

`ifdef ECHO_PRBS_EN
  assign seed      = LFSR_SEED;
  assign pattern_d = lfsr_next(pattern_q);
`else
  assign seed      = COUNT_SEED;
  assign pattern_d = pattern_q + 8'd1;
`endif

  always_ff @(posedge clk_100mhz) begin
    if (reset || load_i) begin
      pattern_q <= seed;
    end else if (advance_i) begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern_o = pattern_q;

endmodule

// File: rtl/uart_echo_tester.sv
// rtl/uart_echo_tester.sv - sends a byte pattern through a buart and checks each echo; ECHO_PRBS_EN selects LFSR pattern
module uart_echo_tester #(
  parameter int NUM_CHARS      = 256,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        start,
  output logic        uart_wr,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        uart_rd,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count
);
  import uart_echo_pkg::*;

  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHARS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        expected_q, expected_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_q, err_d;
  logic              wr, rd, pat_load, pat_advance;
  logic [7:0]        pattern;

  echo_pattern_gen u_pattern (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .load_i     (pat_load),
    .advance_i  (pat_advance),
    .pattern_o  (pattern)
  );

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      timer_q    <= '0;
      expected_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      timer_q    <= timer_d;
      expected_q <= expected_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    timer_d     = timer_q;
    expected_d  = expected_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    wr          = 1'b0;
    rd          = 1'b0;
    pat_load    = 1'b0;
    pat_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Stale bytes left in the buart are drained without being judged
        rd = rx_valid;
        if (start) begin
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = '0;
          index_d   = '0;
          pat_load  = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          wr         = 1'b1;
          expected_d = pattern;
          timer_d    = '0;
          state_d    = ST_WAIT_ECHO;
        end
      end
      ST_WAIT_ECHO: begin
        // An echo arriving in the last timer cycle beats the timeout
        if (rx_valid) begin
          rd = 1'b1;
          if (rx_data != expected_q) err_d = sat_inc16(err_q);
          state_d = ST_NEXT;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          err_d     = sat_inc16(err_q);
          state_d   = ST_FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_NEXT: begin
        if (index_q == IDX_LAST) begin
          state_d = ST_FINISH;
        end else begin
          index_d     = index_q + IDX_W'(1);
          pat_advance = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 16'd0) && !timeout_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign uart_wr   = wr && !reset;
  assign uart_rd   = rd && !reset;
  assign tx_data   = uart_wr ? pattern : 8'h00;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_echo_tester.sv
// tb/tb_uart_echo_tester.sv - scoreboard bench for uart_echo_tester with a far-end echo model
module tb_uart_echo_tester;

  localparam int TMO = 1000;
`ifdef ECHO_PRBS_EN
  localparam int NC = 5;
  localparam logic [7:0] PAT [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
`else
  localparam int NC = 4;
  localparam logic [7:0] PAT [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
`endif

  logic        clk_100mhz = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        uart_wr, uart_rd, busy, done, pass, timeout;
  logic [7:0]  tx_data;
  logic [15:0] err_count;

  logic        echo_valid;
  logic [7:0]  echo_data;
  logic        stale_valid = 1'b0;
  logic [7:0]  stale_data = 8'h00;
  logic        echo_en = 1'b1;
  logic        flip_en = 1'b0;
  logic [7:0]  flip_byte = 8'h00;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int wr_edge = 0;
  int to_edge = 0;
  int rd_pulses = 0;
  logic [7:0]  exp_tx [$];
  logic [17:0] exp_res [$];

  assign rx_valid = echo_valid | stale_valid;
  assign rx_data  = stale_valid ? stale_data : echo_data;

  uart_echo_tester #(.NUM_CHARS(NC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .start      (start),
    .uart_wr    (uart_wr),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .uart_rd    (uart_rd),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .err_count  (err_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Far-end responder: returns each byte a few cycles later, optionally corrupted
  initial begin
    logic [7:0] b;
    bit got;
    echo_valid = 1'b0;
    echo_data  = 8'h00;
    tx_busy    = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (uart_wr && echo_en) begin
        b = tx_data ^ ((flip_en && tx_data == flip_byte) ? 8'h01 : 8'h00);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        tx_busy    = 1'b0;
        echo_data  = b;
        echo_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
          #1;
          if (uart_rd) got = 1'b1;
          else @(negedge clk_100mhz);
        end
        @(negedge clk_100mhz);
        echo_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write or a finished run
  initial begin
    logic done_prev = 1'b0;
    logic to_prev = 1'b0;
    logic [7:0]  e;
    logic [17:0] r;
    forever begin
      @(negedge clk_100mhz);
      #1;
      if (uart_rd) rd_pulses++;
      if (uart_wr || uart_rd) chk("strobe_overlap", int'(uart_wr && uart_rd), 0);
      if (uart_wr) begin
        wr_edge = edge_cnt + 1;
        if (exp_tx.size() == 0) chk("tx_unexpected", int'(tx_data), -1);
        else begin
          e = exp_tx.pop_front();
          chk("tx_data", int'(tx_data), int'(e));
        end
      end
      if (timeout && !to_prev) to_edge = edge_cnt;
      if (done && !done_prev && !reset) begin
        if (exp_res.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          r = exp_res.pop_front();
          chk("err_count", int'(err_count), int'(r[17:2]));
          chk("pass", int'(pass), int'(r[1]));
          chk("timeout", int'(timeout), int'(r[0]));
          chk("busy_at_done", int'(busy), 0);
        end
      end
      done_prev = done;
      to_prev = timeout;
    end
  end

  task automatic pulse_start();
    @(negedge clk_100mhz);
    start = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk({nm, "_done_reached"}, int'(done), 1);
    repeat (2) @(negedge clk_100mhz);
    chk({nm, "_tx_drained"}, exp_tx.size(), 0);
    chk({nm, "_res_drained"}, exp_res.size(), 0);
  endtask

  task automatic push_all(input logic [15:0] err, input logic ps, input logic to);
    for (int i = 0; i < NC; i++) exp_tx.push_back(PAT[i]);
    exp_res.push_back({err, ps, to});
  endtask

  task automatic check_outputs_zero(input string nm);
    #1;
    chk({nm, "_uart_wr"}, int'(uart_wr), 0);
    chk({nm, "_uart_rd"}, int'(uart_rd), 0);
    chk({nm, "_tx_data"}, int'(tx_data), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_pass"}, int'(pass), 0);
    chk({nm, "_timeout"}, int'(timeout), 0);
    chk({nm, "_err"}, int'(err_count), 0);
  endtask

  initial begin
    int rd0;
    repeat (3) @(negedge clk_100mhz);
    reset = 1'b0;
    check_outputs_zero("reset");

    // Clean run; a second start while busy must be ignored
    push_all(16'd0, 1'b1, 1'b0);
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    repeat (8) @(negedge clk_100mhz);
    start = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0;
    wait_done("clean");

    // Third echo has bit0 flipped
    flip_en = 1'b1;
    flip_byte = PAT[2];
    push_all(16'd1, 1'b0, 1'b0);
    pulse_start();
    wait_done("flip");
    flip_en = 1'b0;

    // No echo at all: abort after the timeout
    echo_en = 1'b0;
    exp_tx.push_back(PAT[0]);
    exp_res.push_back({16'd1, 1'b0, 1'b1});
    pulse_start();
    wait_done("timeout");
    chk("timeout_latency", to_edge - wr_edge, TMO);

    // Stale byte in IDLE is drained once and not counted
    echo_en = 1'b1;
    rd0 = rd_pulses;
    @(negedge clk_100mhz);
    stale_data = 8'h55;
    stale_valid = 1'b1;
    #1;
    chk("stale_rd", int'(uart_rd), 1);
    @(negedge clk_100mhz);
    stale_valid = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    chk("stale_rd_pulses", rd_pulses - rd0, 1);
    chk("stale_done_held", int'(done), 1);
    push_all(16'd0, 1'b1, 1'b0);
    pulse_start();
    chk("stale_err_cleared", int'(err_count), 0);
    wait_done("after_stale");

    // Reset while waiting for an echo
    echo_en = 1'b0;
    exp_tx.push_back(PAT[0]);
    pulse_start();
    repeat (20) @(negedge clk_100mhz);
    reset = 1'b1;
    @(negedge clk_100mhz);
    reset = 1'b0;
    check_outputs_zero("midrun_reset");
    exp_tx.delete();
    echo_en = 1'b1;
    push_all(16'd0, 1'b1, 1'b0);
    pulse_start();
    wait_done("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
